// File: rtl/modn_updown_counter_pkg.sv
// Shared definitions for the modulo-N up/down counter family.
package modn_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Count width for a given modulus, never narrower than one bit.
  function automatic int unsigned modn_width(input int unsigned modulus);
    int unsigned w;
    w = $clog2(modulus);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/modn_updown_counter_if.sv
// Control and status bundle of one modulo-N counter stage.
interface modn_updown_counter_if
  import modn_updown_counter_pkg::*;
#(
  parameter int unsigned WIDTH = modn_width(5)
);

  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             oneshot;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             done;
  logic             load_err;

  modport master (
    output en, up, clr, load, load_val, oneshot,
    input  out, tc, done, load_err
  );

  modport slave (
    input  en, up, clr, load, load_val, oneshot,
    output out, tc, done, load_err
  );

endinterface

// File: rtl/modn_updown_counter.sv
// Parametrised modulo-N up/down counter with clear, load, one-shot mode
// and a combinational terminal count for cascading stages.
module modn_updown_counter
  import modn_updown_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 5,
  parameter int unsigned WIDTH   = modn_width(MODULUS)
) (
  input logic                  clk,
  input logic                  reset,
  modn_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] cnt_q;
  logic             done_q;
  logic             err_q;
  logic [WIDTH-1:0] term_val;
  logic             at_term;
  logic             load_over;

  // Wrap by explicit compare so power-of-two moduli behave like the rest.
  function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur, input logic dir);
    if (dir == DIR_UP) begin
      return (cur == MAX_VAL) ? '0 : cur + WIDTH'(1);
    end
    return (cur == '0) ? MAX_VAL : cur - WIDTH'(1);
  endfunction

  assign term_val  = (bus.up == DIR_UP) ? MAX_VAL : '0;
  assign at_term   = (cnt_q == term_val);
  assign load_over = (32'(bus.load_val) >= MODULUS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.clr) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (bus.load) begin
      cnt_q  <= load_over ? MAX_VAL : bus.load_val;
      err_q  <= load_over;
      done_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      // One-shot parks on the terminal value instead of wrapping.
      if (bus.en && !done_q) begin
        if (bus.oneshot && at_term) begin
          done_q <= 1'b1;
        end else begin
          cnt_q <= step(cnt_q, bus.up);
        end
      end
    end
  end

  assign bus.out      = cnt_q;
  assign bus.done     = done_q;
  assign bus.load_err = err_q;
  assign bus.tc       = bus.en & ~done_q & ~bus.clr & ~bus.load & at_term;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Self-checking bench: directed scenarios plus a per-cycle arithmetic model check.
module tb_modn_updown_counter;
  import modn_updown_counter_pkg::*;

  localparam int unsigned MOD = 5;
  localparam int unsigned W   = modn_width(MOD);

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic check_en = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  modn_updown_counter_if #(.WIDTH(W)) bm ();
  modn_updown_counter_if #(.WIDTH(W)) bc0 ();
  modn_updown_counter_if #(.WIDTH(2)) bc1 ();
  modn_updown_counter_if #(.WIDTH(3)) b8 ();

  modn_updown_counter #(.MODULUS(MOD), .WIDTH(W)) dut  (.clk(clk), .reset(reset), .bus(bm));
  modn_updown_counter #(.MODULUS(5),   .WIDTH(W)) u_c0 (.clk(clk), .reset(reset), .bus(bc0));
  modn_updown_counter #(.MODULUS(3),   .WIDTH(2)) u_c1 (.clk(clk), .reset(reset), .bus(bc1));
  modn_updown_counter #(.MODULUS(8),   .WIDTH(3)) u_m8 (.clk(clk), .reset(reset), .bus(b8));

  assign bc1.en = bc0.tc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model of the main instance: modular arithmetic on an integer.
  int   m_out;
  logic m_done;
  logic m_err;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_out <= 0; m_done <= 1'b0; m_err <= 1'b0;
    end else if (bm.clr) begin
      m_out <= 0; m_done <= 1'b0; m_err <= 1'b0;
    end else if (bm.load) begin
      if (int'(bm.load_val) >= int'(MOD)) begin
        m_out <= int'(MOD) - 1; m_err <= 1'b1;
      end else begin
        m_out <= int'(bm.load_val); m_err <= 1'b0;
      end
      m_done <= 1'b0;
    end else begin
      m_err <= 1'b0;
      if (bm.en && !m_done) begin
        if (bm.oneshot && m_out == (bm.up ? int'(MOD) - 1 : 0)) m_done <= 1'b1;
        else if (bm.up) m_out <= (m_out + 1) % int'(MOD);
        else m_out <= (m_out + int'(MOD) - 1) % int'(MOD);
      end
    end
  end

  function automatic logic model_tc();
    return bm.en && !m_done && !bm.clr && !bm.load &&
           (m_out == (bm.up ? int'(MOD) - 1 : 0));
  endfunction

  always @(negedge clk) begin
    if (check_en) begin
      chk("cmp out",      32'(bm.out),      32'(m_out));
      chk("cmp tc",       32'(bm.tc),       32'(model_tc()));
      chk("cmp done",     32'(bm.done),     32'(m_done));
      chk("cmp load_err", 32'(bm.load_err), 32'(m_err));
    end
  end

  task automatic drv(input logic e, input logic u, input logic c, input logic l,
                     input logic [W-1:0] v, input logic o);
    bm.en = e; bm.up = u; bm.clr = c; bm.load = l; bm.load_val = v; bm.oneshot = o;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int e2 [5] = '{2, 1, 0, 4, 3};

  initial begin
    drv(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bc0.en = 1'b0; bc0.up = 1'b1; bc0.clr = 1'b0; bc0.load = 1'b0; bc0.load_val = '0; bc0.oneshot = 1'b0;
    bc1.up = 1'b1; bc1.clr = 1'b0; bc1.load = 1'b0; bc1.load_val = '0; bc1.oneshot = 1'b0;
    b8.en = 1'b0; b8.up = 1'b1; b8.clr = 1'b0; b8.load = 1'b0; b8.load_val = '0; b8.oneshot = 1'b0;

    // Reset state, then free-running up count.
    #1;
    chk("rst out", 32'(bm.out), 32'd0);
    chk("rst done", 32'(bm.done), 32'd0);
    chk("rst load_err", 32'(bm.load_err), 32'd0);
    #9 reset = 1'b1;
    check_en = 1'b1;
    #1;
    for (int i = 0; i < 12; i++) begin
      chk("up out", 32'(bm.out), 32'(i % 5));
      chk("up tc", 32'(bm.tc), 32'((i % 5) == 4));
      cyc();
    end

    // Load 2 then count down; flip direction while at 4.
    drv(1'b0, 1'b0, 1'b0, 1'b1, W'(2), 1'b0);
    cyc();
    drv(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    for (int j = 0; j < 5; j++) begin
      chk("down out", 32'(bm.out), 32'(e2[j]));
      chk("down tc", 32'(bm.tc), 32'(e2[j] == 0));
      if (e2[j] == 4) begin
        bm.up = 1'b1;
        #1 chk("dir flip tc", 32'(bm.tc), 32'd1);
        bm.up = 1'b0;
        #1;
      end
      cyc();
    end

    // Clamped load, then clear beating a clamped load.
    drv(1'b0, 1'b1, 1'b0, 1'b1, W'(7), 1'b0);
    cyc();
    chk("clamp out", 32'(bm.out), 32'd4);
    chk("clamp err", 32'(bm.load_err), 32'd1);
    drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc();
    chk("err pulse end", 32'(bm.load_err), 32'd0);
    chk("hold out", 32'(bm.out), 32'd4);
    drv(1'b0, 1'b1, 1'b0, 1'b1, W'(7), 1'b0);
    cyc();
    chk("clamp err again", 32'(bm.load_err), 32'd1);
    drv(1'b0, 1'b1, 1'b1, 1'b1, W'(7), 1'b0);
    cyc();
    chk("clr wins out", 32'(bm.out), 32'd0);
    chk("clr wins err", 32'(bm.load_err), 32'd0);

    // One-shot: stop at 4, ignore en, resume after load.
    drv(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("os out", 32'(bm.out), 32'(k));
      chk("os tc", 32'(bm.tc), 32'(k == 4));
      chk("os done", 32'(bm.done), 32'd0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      chk("os park out", 32'(bm.out), 32'd4);
      chk("os park done", 32'(bm.done), 32'd1);
      chk("os park tc", 32'(bm.tc), 32'd0);
      cyc();
    end
    bm.oneshot = 1'b0;
    cyc();
    chk("os sticky done", 32'(bm.done), 32'd1);
    chk("os sticky out", 32'(bm.out), 32'd4);
    drv(1'b1, 1'b1, 1'b0, 1'b1, W'(1), 1'b1);
    cyc();
    chk("os reload out", 32'(bm.out), 32'd1);
    chk("os reload done", 32'(bm.done), 32'd0);
    drv(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
    cyc();
    chk("os resume", 32'(bm.out), 32'd2);

    // Asynchronous reset mid-count.
    drv(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
    cyc();
    drv(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(); cyc(); cyc();
    chk("pre-rst out", 32'(bm.out), 32'd3);
    #2 reset = 1'b0;
    #1;
    chk("async rst out", 32'(bm.out), 32'd0);
    chk("async rst done", 32'(bm.done), 32'd0);
    #3 reset = 1'b1;
    cyc();
    chk("post-rst out", 32'(bm.out), 32'd1);

    // Cascade 5 x 3 counts 0..14 and wraps.
    drv(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    bc0.en = 1'b1;
    #1;
    for (int k = 0; k < 20; k++) begin
      chk("cascade val", 32'(bc1.out) * 32'd5 + 32'(bc0.out), 32'(k % 15));
      chk("cascade tc", 32'(bc1.tc), 32'((k % 15) == 14));
      cyc();
    end
    bc0.en = 1'b0;

    // Power-of-two modulus wraps both ways.
    b8.load = 1'b1; b8.load_val = 3'd7;
    cyc();
    chk("m8 load", 32'(b8.out), 32'd7);
    b8.load = 1'b0; b8.en = 1'b1; b8.up = 1'b1;
    #1 chk("m8 tc up", 32'(b8.tc), 32'd1);
    cyc();
    chk("m8 wrap up", 32'(b8.out), 32'd0);
    b8.up = 1'b0;
    #1 chk("m8 tc down", 32'(b8.tc), 32'd1);
    cyc();
    chk("m8 wrap down", 32'(b8.out), 32'd7);
    cyc();
    chk("m8 down step", 32'(b8.out), 32'd6);
    b8.en = 1'b0;

    cyc();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
